// File: rtl/serial_add_sub_unit_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   - FSM state encoding
//   - default operand width
//   - operation counter width helper
package alu_defs;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_BUSY = 2'd1,
    SA_DONE = 2'd2
  } sa_state_e;

  // Bit counter must reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_add_sub_unit_full_adder_1_bit.sv
// Single-bit full adder used once per clock by the serial add/sub unit.
// Ports:
//   a, b, cin  : addend bits and carry in
//   sum, cout  : sum bit and carry out
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub_unit.sv
// Bit-serial adder/subtractor. Operands are latched on an accepted start and
// processed LSB first, one bit per clock, through a single full adder.
// Result and N/Z/C/V flags are registered and presented with a one-cycle
// done pulse; they hold until the next operation completes.
//
// Ports:
//   clock, reset_n : rising-edge clock, async active-low reset
//   start, sub     : request (taken only when ready), 0 = A+B, 1 = A-B
//   a, b           : WIDTH-bit operands, sampled with start
//   ready          : high while idle
//   done           : one-cycle pulse, result/flags valid from this cycle
//   result         : WIDTH-bit sum/difference (modulo 2^WIDTH)
//   flag_n/z/c/v   : negative, zero, carry (1 = no borrow on subtract), overflow
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start, ready=1
// BUSY  | one operand bit per clock through the full adder
// DONE  | result/flags valid, done=1 for one cycle
module serial_add_sub_unit
  import alu_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_e        state_q,  state_d;
  logic [WIDTH-1:0] sa_q,     sa_d;
  logic [WIDTH-1:0] sb_q,     sb_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shifted;

  full_adder_1_bit u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Result register after inserting the current sum bit at the MSB end.
  assign res_shifted = (res_sh_q >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;

    case (state_q)
      SA_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = SA_BUSY;
        end
      end

      SA_BUSY: begin
        res_sh_d = res_shifted;
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = SA_DONE;
          result_d = res_shifted;
          flag_n_d = fa_sum;
          flag_z_d = ~|res_shifted;
          flag_c_d = fa_cout;
          // On the MSB cycle carry_q is exactly the carry into the MSB.
          flag_v_d = carry_q ^ fa_cout;
        end
      end

      SA_DONE: state_d = SA_IDLE;

      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SA_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
    end
  end

  assign ready  = (state_q == SA_IDLE);
  assign done   = (state_q == SA_DONE);
  assign result = result_q;
  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;

endmodule
